// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the memory-stage load/store unit.
// Contents: FSM state enum, RV32I load/store funct3 codes, access-size decode helper.
// Funct3 bits [1:0] select the size (00 byte, 01 half, 1x word); bit 2 selects zero-extension.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Undefined codes (011, 110, 111) all land on word size through bit 1.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/grant/response bundle.
// master (LSU) drives dmem_req/we/addr/wdata/be; slave (memory) drives dmem_gnt/rvalid/rdata.
// A request is accepted in the cycle dmem_req & dmem_gnt; load data returns later with dmem_rvalid.
interface mem_stage_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [3:0]            dmem_be;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [31:0]           dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend: picks the addressed byte/half lane of a load word and sign/zero-extends it.
// Ports: funct3 (size/sign), addr_lo (byte offset), rdata (memory word) -> result (32-bit).
// Purely combinational; half-word lane uses addr_lo[1] only, word ignores the offset.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic        sext;

  always_comb begin
    byte_shift = rdata >> {addr_lo, 3'b000};
    half_shift = rdata >> {addr_lo[1], 4'b0000};
    sext       = ~funct3[2];
    case (f3_size(funct3))
      SZ_B:    result = {{24{sext & byte_shift[7]}}, byte_shift[7:0]};
      SZ_H:    result = {{16{sext & half_shift[15]}}, half_shift[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory-stage LSU; turns MemReadM/MemWriteM/Funct3M into a dmem transaction.
// Ports: clk, rst_n, M-stage controls/address/store data in; StallM, ReadDataM, MisalignM out; dmem master.
// Optional macro LSU_MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of masking the offset.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic                  StallM,
  output logic [31:0]           ReadDataM,
  output logic                  MisalignM,
  mem_stage_lsu_if.master       dmem
);

  lsu_state_t  state, state_nxt;
  lsu_size_t   size;
  logic        access;
  logic        is_load;
  logic        misalign;
  logic        req;
  logic [1:0]  lo;
  logic [31:0] load_res;

  assign access  = MemReadM | MemWriteM;
  assign is_load = MemReadM;            // read wins when both are set
  assign size    = f3_size(Funct3M);
  assign lo      = ALUResultM[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Request fields are driven straight from the M-stage inputs; StallM freezes
  // the E/M register, so they stay stable for as long as dmem_req is held.
  always_comb begin
    dmem.dmem_addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
    dmem.dmem_we   = MemWriteM & ~MemReadM;
    case (size)
      SZ_B: begin
        dmem.dmem_be    = 4'b0001 << lo;
        dmem.dmem_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        dmem.dmem_be    = 4'b0011 << {lo[1], 1'b0};
        dmem.dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      IDLE, REQ: begin
        if (!access) begin
          state_nxt = IDLE;
        end else if (misalign) begin
          state_nxt = DONE;
        end else begin
          req = 1'b1;
          if (dmem.dmem_gnt) state_nxt = is_load ? RSP : DONE;
          else               state_nxt = REQ;
        end
      end
      RSP:     if (dmem.dmem_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated with rst_n so the request and stall drop the moment reset asserts,
  // even while the upstream stages still present an access.
  assign dmem.dmem_req = req & rst_n;
  assign StallM        = access & (state != DONE) & rst_n;

  load_extend u_load_extend (
    .funct3  (Funct3M),
    .addr_lo (lo),
    .rdata   (dmem.dmem_rdata),
    .result  (load_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ReadDataM <= 32'h0;
    else if ((state == RSP) && dmem.dmem_rvalid) ReadDataM <= load_res;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Set on the edge into DONE for a trapped access, so it pulses for exactly that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MisalignM <= 1'b0;
    else        MisalignM <= ((state == IDLE) || (state == REQ)) & access & misalign;
  end
`else
  assign MisalignM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu with a small memory responder.
// Table of load/store vectors plus hand sequences for reset-in-flight, idle and back-to-back.
// Build with or without LSU_MISALIGN_TRAP_EN; misaligned vectors pick their expectation accordingly.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;

  mem_stage_lsu_if #(.ADDR_WIDTH(32)) dif ();

  mem_stage_lsu #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MisalignM  (MisalignM),
    .dmem       (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;
    int          exp_stall;
    int          exp_reqs;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                              input logic [31:0] rdata, input logic [31:0] eaddr, input logic [31:0] ewdata,
                              input logic [3:0] ebe, input logic ewe, input int est, input int erq,
                              input logic [31:0] erd, input logic emis);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.gnt_dly = dly; v.rdata = rdata; v.exp_addr = eaddr; v.exp_wdata = ewdata;
    v.exp_be = ebe; v.exp_we = ewe; v.exp_stall = est; v.exp_reqs = erq;
    v.exp_rd = erd; v.exp_mis = emis;
    return v;
  endfunction

  // Memory model: grants after gnt_dly request cycles, returns rdata the cycle after the grant.
  task automatic run_vec(input vec_t v);
    int stalls;
    int reqs;
    bit granted;
    bit done;
    stalls = 0; reqs = 0; granted = 0; done = 0;
    @(negedge clk);
    MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wdata; dif.dmem_rdata = v.rdata;
    for (int c = 0; c < 30 && !done; c++) begin
      dif.dmem_gnt = 1'b0;
      dif.dmem_rvalid = 1'b0;
      #1;
      if (StallM) begin
        stalls++;
        if (dif.dmem_req) begin
          chk({v.name, " addr"}, dif.dmem_addr, v.exp_addr);
          chk({v.name, " be"}, 32'(dif.dmem_be), 32'(v.exp_be));
          chk({v.name, " we"}, 32'(dif.dmem_we), 32'(v.exp_we));
          if (v.exp_we) chk({v.name, " wdata"}, dif.dmem_wdata, v.exp_wdata);
          if (reqs == v.gnt_dly) begin
            dif.dmem_gnt = 1'b1;
            granted = 1'b1;
          end
          reqs++;
        end else if (granted) begin
          dif.dmem_rvalid = 1'b1;
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
        chk({v.name, " ReadDataM"}, ReadDataM, v.exp_rd);
        chk({v.name, " MisalignM"}, 32'(MisalignM), 32'(v.exp_mis));
        chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
        chk({v.name, " req cycles"}, 32'(reqs), 32'(v.exp_reqs));
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: StallM still %b after 30 cycles, required 0", v.name, StallM);
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(negedge clk);
    #1;
    chk({v.name, " idle StallM"}, 32'(StallM), 32'd0);
    chk({v.name, " idle req"}, 32'(dif.dmem_req), 32'd0);
    chk({v.name, " idle MisalignM"}, 32'(MisalignM), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk("LB 0x103", 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234,
                 32'h100, 32'h0, 4'b1000, 0, 2, 1, 32'hFFFF_FF80, 0);
    tbl[1]  = mk("SH 0x202", 0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 3, 32'h0,
                 32'h200, 32'hBEEF_BEEF, 4'b1100, 1, 4, 4, 32'hFFFF_FF80, 0);
    tbl[2]  = mk("LHU 0x10", 1, 0, 3'b101, 32'h10, 32'h0, 0, 32'h1234_F00D,
                 32'h10, 32'h0, 4'b0011, 0, 2, 1, 32'h0000_F00D, 0);
    tbl[3]  = mk("LW 0x14", 1, 0, 3'b010, 32'h14, 32'h0, 1, 32'hCAFE_BABE,
                 32'h14, 32'h0, 4'b1111, 0, 3, 2, 32'hCAFE_BABE, 0);
    tbl[4]  = mk("LH 0x12", 1, 0, 3'b001, 32'h12, 32'h0, 0, 32'h8001_0000,
                 32'h10, 32'h0, 4'b1100, 0, 2, 1, 32'hFFFF_8001, 0);
    tbl[5]  = mk("LBU 0x101", 1, 0, 3'b100, 32'h101, 32'h0, 0, 32'h0000_9A00,
                 32'h100, 32'h0, 4'b0010, 0, 2, 1, 32'h0000_009A, 0);
    tbl[6]  = mk("SB 0x3", 0, 1, 3'b000, 32'h3, 32'h1234_5678, 0, 32'h0,
                 32'h0, 32'h7878_7878, 4'b1000, 1, 1, 1, 32'h0000_009A, 0);
    tbl[7]  = mk("S f3=111 0x2C", 0, 1, 3'b111, 32'h2C, 32'h0102_0304, 0, 32'h0,
                 32'h2C, 32'h0102_0304, 4'b1111, 1, 1, 1, 32'h0000_009A, 0);
    tbl[8]  = mk("LW rd+wr 0x20", 1, 1, 3'b010, 32'h20, 32'hFFFF_FFFF, 2, 32'h1122_3344,
                 32'h20, 32'h0, 4'b1111, 0, 4, 3, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[9]  = mk("LW 0x401 mis", 1, 0, 3'b010, 32'h401, 32'h0, 0, 32'h5566_7788,
                 32'h400, 32'h0, 4'b1111, 0, 1, 0, 32'h1122_3344, 1);
    tbl[10] = mk("LH 0x3 mis", 1, 0, 3'b001, 32'h3, 32'h0, 0, 32'hABCD_1234,
                 32'h0, 32'h0, 4'b1100, 0, 1, 0, 32'h1122_3344, 1);
    tbl[11] = mk("SH 0x1 mis", 0, 1, 3'b001, 32'h1, 32'h0000_7E57, 0, 32'h0,
                 32'h0, 32'h7E57_7E57, 4'b0011, 1, 1, 0, 32'h1122_3344, 1);
`else
    tbl[9]  = mk("LW 0x401 mis", 1, 0, 3'b010, 32'h401, 32'h0, 0, 32'h5566_7788,
                 32'h400, 32'h0, 4'b1111, 0, 2, 1, 32'h5566_7788, 0);
    tbl[10] = mk("LH 0x3 mis", 1, 0, 3'b001, 32'h3, 32'h0, 0, 32'hABCD_1234,
                 32'h0, 32'h0, 4'b1100, 0, 2, 1, 32'hFFFF_ABCD, 0);
    tbl[11] = mk("SH 0x1 mis", 0, 1, 3'b001, 32'h1, 32'h0000_7E57, 0, 32'h0,
                 32'h0, 32'h7E57_7E57, 4'b0011, 1, 1, 1, 32'hFFFF_ABCD, 0);
`endif

    rst_n = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = 32'h0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("reset StallM", 32'(StallM), 32'd0);
    chk("reset req", 32'(dif.dmem_req), 32'd0);
    chk("reset ReadDataM", ReadDataM, 32'h0);
    chk("reset MisalignM", 32'(MisalignM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while waiting for a load response; the late rvalid must be ignored.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h40;
    #1;
    chk("rst-in-RSP req", 32'(dif.dmem_req), 32'd1);
    dif.dmem_gnt = 1'b1;
    @(negedge clk);
    dif.dmem_gnt = 1'b0;
    #1;
    chk("rst-in-RSP rsp stall", 32'(StallM), 32'd1);
    chk("rst-in-RSP rsp req", 32'(dif.dmem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst-in-RSP req drop", 32'(dif.dmem_req), 32'd0);
    chk("rst-in-RSP stall drop", 32'(StallM), 32'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    dif.dmem_rvalid = 1'b0;
    #1;
    chk("stale rvalid ReadDataM", ReadDataM, 32'h0);
    chk("stale rvalid req", 32'(dif.dmem_req), 32'd0);

    // Ten idle cycles with stray gnt/rvalid on odd cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dif.dmem_gnt = i[0];
      dif.dmem_rvalid = i[0];
      #1;
      chk("idle StallM", 32'(StallM), 32'd0);
      chk("idle req", 32'(dif.dmem_req), 32'd0);
    end
    dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0;
    chk("idle ReadDataM", ReadDataM, 32'h0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Back-to-back: SW retires in DONE, LW is presented next with no gap,
    // and must still begin from IDLE with a fresh request.
    @(negedge clk);
    MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h50; WriteDataM = 32'h0BAD_F00D;
    #1;
    chk("b2b SW req", 32'(dif.dmem_req), 32'd1);
    dif.dmem_gnt = 1'b1;
    @(negedge clk);
    dif.dmem_gnt = 1'b0;
    #1;
    chk("b2b SW done stall", 32'(StallM), 32'd0);
    chk("b2b SW done req", 32'(dif.dmem_req), 32'd0);
    @(negedge clk);
    MemWriteM = 1'b0; MemReadM = 1'b1; ALUResultM = 32'h54; dif.dmem_rdata = 32'h7654_3210;
    #1;
    chk("b2b LW idle stall", 32'(StallM), 32'd1);
    chk("b2b LW idle req", 32'(dif.dmem_req), 32'd1);
    chk("b2b LW addr", dif.dmem_addr, 32'h54);
    dif.dmem_gnt = 1'b1;
    @(negedge clk);
    dif.dmem_gnt = 1'b0;
    dif.dmem_rvalid = 1'b1;
    @(negedge clk);
    dif.dmem_rvalid = 1'b0;
    #1;
    chk("b2b LW done stall", 32'(StallM), 32'd0);
    chk("b2b LW ReadDataM", ReadDataM, 32'h7654_3210);
    MemReadM = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
